// File: rtl/axi_lite_fifo_ctrl_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the FIFO write-side controller (slave).
interface axi_lite_if;
  logic [3:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_fifo_ctrl.sv
// AXI4-Lite slave on the clk_axi side of the async FIFO: DATA pushes with full back-pressure,
// status/drop-count reads, flush strobes.
//  state  | meaning
//  W_IDLE | collecting AW and W independently
//  W_EXEC | performing the latched write (may stall while FIFO is full)
//  W_RESP | presenting bresp until bready
//  R_IDLE | ready for a read address
//  R_RESP | presenting rdata/rresp until rready
module axi_lite_fifo_ctrl #(
  parameter int LVL_W        = 5,
  parameter int FULL_TIMEOUT = 16,
  parameter int DROP_W       = 16
) (
  input  logic             clk_axi,
  input  logic             axi_resetn,
  axi_lite_if.slave        axi,
  output logic             fifo_wr_en,
  output logic [31:0]      fifo_wr_data,
  output logic             fifo_flush,
  input  logic             fifo_full,
  input  logic [LVL_W-1:0] fifo_wr_level
);

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_DROP    = 2'd3;
  localparam int         STALL_W     = $clog2(FULL_TIMEOUT + 2);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(FULL_TIMEOUT);

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic               aw_held, w_held;
  logic [3:0]         aw_addr_q;
  logic [31:0]        w_data_q;
  logic [3:0]         w_strb_q;
  logic [STALL_W-1:0] stall_cnt;
  logic [DROP_W-1:0]  drop_cnt;
  logic [31:0]        last_pushed;
  logic [1:0]         bresp_q;
  logic [31:0]        rdata_q;
  logic [1:0]         rresp_q;

  logic        aw_hs, w_hs, ar_hs;
  logic        exec_done, stall_inc, drop_inc, drop_clr;
  logic [1:0]  exec_resp;
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;
  logic [31:0] status_word;

  // Ready/valid outputs are decoded purely from registered state.
  assign axi.awready = (w_state == W_IDLE) && !aw_held;
  assign axi.wready  = (w_state == W_IDLE) && !w_held;
  assign axi.bvalid  = (w_state == W_RESP);
  assign axi.bresp   = bresp_q;
  assign axi.arready = (r_state == R_IDLE);
  assign axi.rvalid  = (r_state == R_RESP);
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;

  assign aw_hs = axi.awvalid && axi.awready;
  assign w_hs  = axi.wvalid && axi.wready;
  assign ar_hs = axi.arvalid && axi.arready;

  assign fifo_wr_data = fifo_wr_en ? w_data_q : '0;

  always_ff @(posedge clk_axi or negedge axi_resetn) begin
    if (!axi_resetn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next     = w_state;
    fifo_wr_en = 1'b0;
    fifo_flush = 1'b0;
    exec_done  = 1'b0;
    exec_resp  = RESP_OKAY;
    stall_inc  = 1'b0;
    drop_inc   = 1'b0;
    drop_clr   = 1'b0;
    case (w_state)
      W_IDLE: begin
        if ((aw_held || aw_hs) && (w_held || w_hs)) w_next = W_EXEC;
      end
      W_EXEC: begin
        exec_done = 1'b1;
        if (aw_addr_q[1:0] != 2'b00) begin
          exec_resp = RESP_SLVERR;
        end else begin
          case (aw_addr_q[3:2])
            REG_DATA: begin
              if (w_strb_q != 4'hF) begin
                exec_resp = RESP_SLVERR;
              end else if (!fifo_full) begin
                fifo_wr_en = 1'b1;
              end else if (stall_cnt == STALL_MAX) begin
                exec_resp = RESP_SLVERR;
                drop_inc  = 1'b1;
              end else begin
                exec_done = 1'b0;
                stall_inc = 1'b1;
              end
            end
            REG_STATUS: exec_resp = RESP_SLVERR;
            REG_CTRL:   fifo_flush = w_data_q[0];
            REG_DROP:   drop_clr = 1'b1;
          endcase
        end
        if (exec_done) w_next = W_RESP;
      end
      W_RESP: begin
        if (axi.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_axi or negedge axi_resetn) begin
    if (!axi_resetn) begin
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      aw_addr_q   <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      stall_cnt   <= '0;
      drop_cnt    <= '0;
      last_pushed <= '0;
      bresp_q     <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= axi.awaddr;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= axi.wdata;
        w_strb_q <= axi.wstrb;
      end
      // Hold flags drop as the pair is consumed, overriding a same-cycle capture.
      if (w_state == W_IDLE && w_next == W_EXEC) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
      if (stall_inc) stall_cnt <= stall_cnt + STALL_W'(1);
      else if (w_state == W_RESP && axi.bready) stall_cnt <= '0;
      if (exec_done) bresp_q <= exec_resp;
      if (fifo_wr_en) last_pushed <= w_data_q;
      if (drop_clr) drop_cnt <= '0;
      else if (drop_inc && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

  always_comb begin
    status_word = '0;
    status_word[8 +: LVL_W] = fifo_wr_level;
    status_word[1] = (fifo_wr_level == '0);
    status_word[0] = fifo_full;
  end

  always_comb begin
    r_next  = r_state;
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (r_state)
      R_IDLE: if (axi.arvalid) r_next = R_RESP;
      R_RESP: if (axi.rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
    if (axi.araddr[1:0] != 2'b00) begin
      rd_resp = RESP_SLVERR;
    end else begin
      case (axi.araddr[3:2])
        REG_DATA:   rd_data = last_pushed;
        REG_STATUS: rd_data = status_word;
        REG_CTRL:   rd_data = '0;
        REG_DROP:   rd_data = 32'(drop_cnt);
      endcase
    end
  end

  always_ff @(posedge clk_axi or negedge axi_resetn) begin
    if (!axi_resetn) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= rd_data;
      rresp_q <= rd_resp;
    end
  end

endmodule

// File: tb/tb_axi_lite_fifo_ctrl.sv
// Directed bench for axi_lite_fifo_ctrl with FULL_TIMEOUT=4; expected values are hand-computed.
module tb_axi_lite_fifo_ctrl;
  logic        clk_axi = 1'b0;
  logic        axi_resetn = 1'b0;
  logic        fifo_wr_en;
  logic [31:0] fifo_wr_data;
  logic        fifo_flush;
  logic        fifo_full = 1'b0;
  logic [4:0]  fifo_wr_level = 5'd0;

  axi_lite_if bus ();

  axi_lite_fifo_ctrl #(.LVL_W(5), .FULL_TIMEOUT(4), .DROP_W(16)) dut (
    .clk_axi       (clk_axi),
    .axi_resetn    (axi_resetn),
    .axi           (bus),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_wr_data  (fifo_wr_data),
    .fifo_flush    (fifo_flush),
    .fifo_full     (fifo_full),
    .fifo_wr_level (fifo_wr_level)
  );

  always #5 clk_axi = ~clk_axi;

  int total = 0;
  int bad = 0;
  int push_cnt = 0;
  int flush_cnt = 0;
  logic [31:0] last_push = '0;

  always @(negedge clk_axi) begin
    if (axi_resetn) begin
      if (fifo_wr_en) begin
        push_cnt++;
        last_push = fifo_wr_data;
      end
      if (fifo_flush) flush_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_axi);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat);
    bit aw_done = 0;
    bit w_done = 0;
    bit aw_acc, w_acc;
    int n = 0;
    bus.awaddr = a; bus.awvalid = 1'b1;
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
    bus.bready = 1'b1;
    while (!(aw_done && w_done) && n < 50) begin
      aw_acc = bus.awvalid && bus.awready;
      w_acc  = bus.wvalid && bus.wready;
      tick();
      n++;
      if (aw_acc) begin bus.awvalid = 1'b0; aw_done = 1; end
      if (w_acc)  begin bus.wvalid = 1'b0;  w_done = 1;  end
    end
    chk("aw_w_accepted", 32'(aw_done && w_done), 32'd1);
    lat = 0;
    while (!bus.bvalid && lat < 50) begin
      tick();
      lat++;
    end
    chk("bvalid_seen", 32'(bus.bvalid), 32'd1);
    resp = bus.bresp;
    tick();
    bus.bready = 1'b0;
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
    while (!bus.arready && n < 50) begin tick(); n++; end
    tick();
    bus.arvalid = 1'b0;
    chk("rvalid_next_cycle", 32'(bus.rvalid), 32'd1);
    d = bus.rdata;
    resp = bus.rresp;
    tick();
    bus.rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  rr;
    logic [1:0]  br;
    int lat;
    int pc;
    int fc;

    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    repeat (3) tick();
    chk("rst_awready", 32'(bus.awready), 32'd1);
    chk("rst_wready", 32'(bus.wready), 32'd1);
    chk("rst_arready", 32'(bus.arready), 32'd1);
    chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_flush", 32'(fifo_flush), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    axi_resetn = 1'b1;
    tick();

    // AW and W in the same cycle: push next cycle, response the cycle after
    bus.awaddr = 4'h0; bus.awvalid = 1'b1;
    bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("t2_wr_en", 32'(fifo_wr_en), 32'd1);
    chk("t2_wr_data", fifo_wr_data, 32'hDEADBEEF);
    chk("t2_no_early_b", 32'(bus.bvalid), 32'd0);
    tick();
    chk("t2_bvalid", 32'(bus.bvalid), 32'd1);
    chk("t2_bresp", 32'(bus.bresp), 32'd0);
    tick();
    bus.bready = 1'b0;
    chk("t2_b_done", 32'(bus.bvalid), 32'd0);
    chk("t2_push_cnt", 32'(push_cnt), 32'd1);

    // status and data readback
    axi_read(4'h0, rd, rr);
    chk("t5_data", rd, 32'hDEADBEEF);
    fifo_wr_level = 5'd16; fifo_full = 1'b1;
    axi_read(4'h4, rd, rr);
    chk("t5_status_full", rd, 32'h0000_1001);
    chk("t5_status_rresp", 32'(rr), 32'd0);
    fifo_wr_level = 5'd0; fifo_full = 1'b0;
    axi_read(4'h4, rd, rr);
    chk("t5_status_empty", rd, 32'h0000_0002);
    fifo_wr_level = 5'd5;
    axi_read(4'h4, rd, rr);
    chk("t5_status_lvl5", rd, 32'h0000_0500);

    // full timeout -> drop after FULL_TIMEOUT+1 exec cycles
    fifo_full = 1'b1;
    pc = push_cnt;
    axi_write(4'h0, 32'h11111111, 4'hF, br, lat);
    chk("t3_drop_bresp", 32'(br), 32'd2);
    chk("t3_drop_lat", 32'(lat), 32'd5);
    chk("t3_no_push", 32'(push_cnt), 32'(pc));
    fifo_full = 1'b0;
    axi_read(4'hC, rd, rr);
    chk("t3_drop_cnt1", rd, 32'd1);

    // full releases after 2 stall cycles -> push
    fifo_full = 1'b1;
    pc = push_cnt;
    fork
      axi_write(4'h0, 32'h22222222, 4'hF, br, lat);
      begin
        tick();
        tick();
        fifo_full = 1'b0;
      end
    join
    chk("t3_release_bresp", 32'(br), 32'd0);
    chk("t3_release_lat", 32'(lat), 32'd2);
    chk("t3_release_push", 32'(push_cnt), 32'(pc + 1));
    chk("t3_release_data", last_push, 32'h22222222);
    axi_read(4'hC, rd, rr);
    chk("t3_drop_still1", rd, 32'd1);
    axi_read(4'h0, rd, rr);
    chk("t3_last_pushed", rd, 32'h22222222);

    // reset while stalled on full
    fifo_full = 1'b1;
    bus.awaddr = 4'h0; bus.awvalid = 1'b1;
    bus.wdata = 32'h33333333; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    tick();
    tick();
    chk("t1_stalled_awready", 32'(bus.awready), 32'd0);
    axi_resetn = 1'b0;
    #1;
    chk("t1_bvalid", 32'(bus.bvalid), 32'd0);
    chk("t1_awready", 32'(bus.awready), 32'd1);
    chk("t1_wready", 32'(bus.wready), 32'd1);
    chk("t1_arready", 32'(bus.arready), 32'd1);
    chk("t1_rdata", bus.rdata, 32'd0);
    chk("t1_wr_data", fifo_wr_data, 32'd0);
    tick();
    axi_resetn = 1'b1;
    fifo_full = 1'b0;
    repeat (3) tick();
    chk("t1_no_resp_after", 32'(bus.bvalid), 32'd0);
    bus.bready = 1'b0;
    axi_read(4'hC, rd, rr);
    chk("t1_drop_cleared", rd, 32'd0);
    axi_read(4'h0, rd, rr);
    chk("t1_last_cleared", rd, 32'd0);

    // W three cycles ahead of AW, bready held low
    bus.wdata = 32'h44444444; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b0;
    tick();
    bus.wvalid = 1'b0;
    chk("t4_wready_low", 32'(bus.wready), 32'd0);
    chk("t4_awready_high", 32'(bus.awready), 32'd1);
    chk("t4_no_push_yet", 32'(fifo_wr_en), 32'd0);
    tick();
    tick();
    bus.awaddr = 4'h0; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    chk("t4_push", 32'(fifo_wr_en), 32'd1);
    chk("t4_push_data", fifo_wr_data, 32'h44444444);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t4_bvalid_held", 32'(bus.bvalid), 32'd1);
      chk("t4_awready_blocked", 32'(bus.awready), 32'd0);
      tick();
    end
    chk("t4_bresp", 32'(bus.bresp), 32'd0);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    chk("t4_b_done", 32'(bus.bvalid), 32'd0);
    chk("t4_awready_back", 32'(bus.awready), 32'd1);

    // error writes, flush, drop clear
    axi_write(4'h4, 32'h1, 4'hF, br, lat);
    chk("t6_status_wr", 32'(br), 32'd2);
    axi_write(4'h2, 32'h1, 4'hF, br, lat);
    chk("t6_misaligned_wr", 32'(br), 32'd2);
    pc = push_cnt;
    axi_write(4'h0, 32'h55555555, 4'h3, br, lat);
    chk("t6_partial_strb", 32'(br), 32'd2);
    chk("t6_partial_no_push", 32'(push_cnt), 32'(pc));
    axi_read(4'h0, rd, rr);
    chk("t6_data_unchanged", rd, 32'h44444444);
    fc = flush_cnt;
    axi_write(4'h8, 32'h1, 4'hF, br, lat);
    chk("t6_flush_bresp", 32'(br), 32'd0);
    chk("t6_flush_pulse", 32'(flush_cnt), 32'(fc + 1));
    axi_write(4'h8, 32'h0, 4'hF, br, lat);
    chk("t6_no_flush", 32'(flush_cnt), 32'(fc + 1));
    fifo_full = 1'b1;
    axi_write(4'h0, 32'h66666666, 4'hF, br, lat);
    fifo_full = 1'b0;
    chk("t6_drop_again", 32'(br), 32'd2);
    axi_read(4'hC, rd, rr);
    chk("t6_drop_cnt1", rd, 32'd1);
    axi_write(4'hC, 32'h0, 4'hF, br, lat);
    chk("t6_clear_bresp", 32'(br), 32'd0);
    axi_read(4'hC, rd, rr);
    chk("t6_drop_zero", rd, 32'd0);
    axi_read(4'h8, rd, rr);
    chk("t6_ctrl_read", rd, 32'd0);
    axi_read(4'h1, rd, rr);
    chk("t6_misaligned_rresp", 32'(rr), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
